// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns a single-cycle datapath load/store into a req/gnt/rvalid
// word-bus transaction, stalling the core until it completes. Optional abort timer: LSU_TIMEOUT_EN.
module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_rdata;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic        r_bus_req;
  logic        r_bus_we;
  logic        r_err;
  logic [1:0]  r_lane;
  logic [2:0]  r_f3;

  logic        w_op;
  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_timeout;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0, h};
      default: load_extend = word;
    endcase
  endfunction

  assign w_op = mem_read | mem_write;

  always_comb begin
    w_legal = 1'b0;
    if (mem_read && !mem_write) begin
      case (func3)
        3'b000, 3'b100: w_legal = 1'b1;
        3'b001, 3'b101: w_legal = !addr[0];
        3'b010:         w_legal = (addr[1:0] == 2'b00);
        default:        w_legal = 1'b0;
      endcase
    end else if (mem_write && !mem_read) begin
      case (func3)
        3'b000:  w_legal = 1'b1;
        3'b001:  w_legal = !addr[0];
        3'b010:  w_legal = (addr[1:0] == 2'b00);
        default: w_legal = 1'b0;
      endcase
    end
  end

  // Stores replicate the datum across lanes so the enables alone select the target bytes.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    if (!mem_read) begin
      case (func3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << addr[1:0];
          w_wdata = {2{wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = wdata;
        end
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero in IDLE, so it is cleared on entry to REQ.
  always_ff @(posedge clk) begin
    if (rst_n || r_state == IDLE) r_cnt <= '0;
    else                          r_cnt <= r_cnt + CNT_W'(1);
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= IDLE;
      r_rdata     <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_err       <= 1'b0;
      r_lane      <= '0;
      r_f3        <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_op && w_legal) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_write;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_lane      <= addr[1:0];
            r_f3        <= func3;
            r_state     <= REQ;
          end else if (w_op) begin
            r_err <= 1'b1;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= r_bus_we ? DONE : WAIT_R;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_state   <= DONE;
          end
        end
        WAIT_R: begin
          if (bus_rvalid) begin
            r_rdata <= load_extend(r_f3, r_lane, bus_rdata);
            r_state <= DONE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall     = (r_state == REQ) || (r_state == WAIT_R) ||
                     (r_state == IDLE && w_op && w_legal);
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Randomized self-checking bench for lsu_bus_ctrl against a transaction-level reference model.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata = 32'h0;

`ifdef LSU_TIMEOUT_EN
  localparam int MAXD = 1;
`else
  localparam int MAXD = 3;
`endif

  // Observations of the last transaction.
  int          o_nstall, o_nreq;
  bit          o_stable, o_hung;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be;
  logic        o_we, o_err, o_err_next;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .func3(func3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit ref_legal(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    int size;
    size = int'(f3) % 4;
    if (rd == wr) return 1'b0;
    if (wr && f3 > 3'd2) return 1'b0;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
    if (size == 1 && a % 2 != 0) return 1'b0;
    if (size == 2 && a % 4 != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, int lane, logic [31:0] w);
    logic [31:0] v;
    if (int'(f3) % 4 == 0) begin
      v = (w >> (8 * lane)) % 256;
      if (f3 < 3'd4 && v >= 128) v = v + 32'hFFFFFF00;
    end else if (int'(f3) % 4 == 1) begin
      v = (w >> (16 * (lane / 2))) % 65536;
      if (f3 < 3'd4 && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(bit rd, logic [2:0] f3, int lane);
    int v;
    if (rd)             v = 15;
    else if (f3 == 0)   v = 1 << lane;
    else if (f3 == 1)   v = 3 << lane;
    else                v = 15;
    return 4'(v);
  endfunction

  function automatic logic [31:0] ref_wdata(logic [2:0] f3, logic [31:0] wd);
    if (f3 == 0) return (wd % 256) * 32'h01010101;
    if (f3 == 1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  // Acts as the bus slave for one op: grants after gdly REQ cycles, returns read data rdly
  // cycles after the earliest legal slot, and records what the DUT did.
  task automatic xact(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int gdly, input int rdly, input logic [31:0] rw);
    int gnt_at;
    bit done;
    o_nstall = 0; o_nreq = 0; o_stable = 1'b1; o_hung = 1'b0;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    o_err = 1'b0; o_err_next = 1'b0; o_rdata = '0;
    gnt_at = -1;
    done = 1'b0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; func3 = f3; addr = a; wdata = wd;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = rw;
    @(negedge clk);
    if (!stall) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      o_err = err;
      if (stall) o_nstall++;
      if (bus_req) o_nreq++;
      @(posedge clk); #1;
      @(negedge clk);
      o_err_next = err;
      if (bus_req) o_nreq++;
      o_rdata = rdata;
      return;
    end
    o_nstall = 1;
    for (int c = 1; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      bus_gnt = bus_req && (o_nreq == gdly);
      if (bus_gnt) gnt_at = c;
      bus_rvalid = rd && (gnt_at >= 0) && (c == gnt_at + 1 + rdly);
      @(negedge clk);
      if (bus_req) begin
        if (o_nreq == 0) begin
          o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be; o_we = bus_we;
        end else if (bus_addr !== o_addr || bus_wdata !== o_wdata ||
                     bus_be !== o_be || bus_we !== o_we) begin
          o_stable = 1'b0;
        end
        o_nreq++;
      end
      if (stall) o_nstall++;
      else begin
        done = 1'b1;
        o_rdata = rdata;
        o_err = err;
      end
    end
    o_hung = !done;
    if (o_hung) begin
      @(posedge clk); #1;
      rst_n = 1'b1; bus_gnt = 1'b0; bus_rvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = '0; addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got %h want 0", bus_addr); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_wdata got %h want 0", bus_wdata); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_we got %b want 0", bus_we); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (bus_be !== 4'b0000) begin errors++; $display("FAIL reset_bus_be got %b want 0000", bus_be); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    @(posedge clk); #1;
    rst_n = 1'b0;
  endtask

  task automatic test_load_word();
    xact(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    checks++; if (o_hung) begin errors++; $display("FAIL lw_hung got hung want done"); end
    checks++; if (o_nstall != 3) begin errors++; $display("FAIL lw_stall got %0d want 3", o_nstall); end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", o_rdata); end
    checks++; if (o_be !== 4'b1111) begin errors++; $display("FAIL lw_be got %b want 1111", o_be); end
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 100", o_addr); end
    checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL lw_we got %b want 0", o_we); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL lw_err got %b want 0", o_err); end
    exp_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_load_byte();
    xact(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80FFFF7F);
    checks++; if (o_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", o_rdata); end
    xact(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 1, 32'h80FFFF7F);
    checks++; if (o_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h want 00000080", o_rdata); end
    checks++; if (o_nstall != 4) begin errors++; $display("FAIL lbu_stall got %0d want 4", o_nstall); end
    exp_rdata = 32'h00000080;
  endtask

  task automatic test_store_half();
    xact(1'b0, 1'b1, 3'b001, 32'h302, 32'h1234ABCD, 3, 0, 32'h0);
    checks++; if (o_nreq != 4) begin errors++; $display("FAIL sh_req_cycles got %0d want 4", o_nreq); end
    checks++; if (!o_stable) begin errors++; $display("FAIL sh_stable got unstable want stable"); end
    checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", o_be); end
    checks++; if (o_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", o_wdata); end
    checks++; if (o_addr !== 32'h300) begin errors++; $display("FAIL sh_addr got %h want 300", o_addr); end
    checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sh_we got %b want 1", o_we); end
    checks++; if (o_nstall != 5) begin errors++; $display("FAIL sh_stall got %0d want 5", o_nstall); end
    checks++; if (o_rdata !== exp_rdata) begin errors++; $display("FAIL sh_rdata_kept got %h want %h", o_rdata, exp_rdata); end
  endtask

  task automatic test_illegal();
    bit          rd [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit          wr [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3 [4]  = '{3'b010, 3'b010, 3'b001, 3'b100};
    logic [31:0] ad [4]  = '{32'h101, 32'h100, 32'h201, 32'h400};
    for (int i = 0; i < 4; i++) begin
      xact(rd[i], wr[i], f3[i], ad[i], 32'h55AA55AA, 0, 0, 32'h0);
      checks++; if (o_nstall != 0) begin errors++; $display("FAIL ill%0d_stall got %0d want 0", i, o_nstall); end
      checks++; if (o_nreq != 0) begin errors++; $display("FAIL ill%0d_req got %0d want 0", i, o_nreq); end
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL ill%0d_err got %b want 1", i, o_err); end
      checks++; if (o_err_next !== 1'b0) begin errors++; $display("FAIL ill%0d_err_pulse got %b want 0", i, o_err_next); end
      checks++; if (o_rdata !== exp_rdata) begin errors++; $display("FAIL ill%0d_rdata got %h want %h", i, o_rdata, exp_rdata); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bit          rd, wr, lg;
    logic [2:0]  f3;
    logic [31:0] a, wd, rw;
    int          gd, rl, exp_stall;
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom % 2); wr = !rd;
      if ($urandom % 10 == 0) begin rd = 1'b1; wr = 1'b1; end
      if ($urandom % 5 == 0) f3 = 3'($urandom % 8);
      else if (rd)           f3 = ld_f3[$urandom % 5];
      else                   f3 = 3'($urandom % 3);
      a = $urandom; wd = $urandom; rw = $urandom;
      gd = int'($urandom % (MAXD + 1)); rl = int'($urandom % (MAXD + 1));
      lg = ref_legal(rd, wr, f3, a);
      xact(rd, wr, f3, a, wd, gd, rl, rw);
      checks++; if (o_hung) begin errors++; $display("FAIL rand%0d_hung got hung want done", i); end
      if (lg) begin
        exp_stall = 1 + (gd + 1) + (rd ? rl + 1 : 0);
        if (rd) exp_rdata = ref_load(f3, int'(a % 4), rw);
        checks++; if (o_nstall != exp_stall) begin errors++; $display("FAIL rand%0d_stall got %0d want %0d", i, o_nstall, exp_stall); end
        checks++; if (o_nreq != gd + 1) begin errors++; $display("FAIL rand%0d_req got %0d want %0d", i, o_nreq, gd + 1); end
        checks++; if (!o_stable) begin errors++; $display("FAIL rand%0d_stable got unstable want stable", i); end
        checks++; if (o_addr !== (a / 4) * 4) begin errors++; $display("FAIL rand%0d_addr got %h want %h", i, o_addr, (a / 4) * 4); end
        checks++; if (o_be !== ref_be(rd, f3, int'(a % 4))) begin errors++; $display("FAIL rand%0d_be got %b want %b", i, o_be, ref_be(rd, f3, int'(a % 4))); end
        checks++; if (o_we !== wr) begin errors++; $display("FAIL rand%0d_we got %b want %b", i, o_we, wr); end
        if (wr) begin
          checks++; if (o_wdata !== ref_wdata(f3, wd)) begin errors++; $display("FAIL rand%0d_wdata got %h want %h", i, o_wdata, ref_wdata(f3, wd)); end
        end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rand%0d_err got %b want 0", i, o_err); end
      end else begin
        checks++; if (o_nstall != 0) begin errors++; $display("FAIL rand%0d_ill_stall got %0d want 0", i, o_nstall); end
        checks++; if (o_nreq != 0) begin errors++; $display("FAIL rand%0d_ill_req got %0d want 0", i, o_nreq); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL rand%0d_ill_err got %b want 1", i, o_err); end
      end
      checks++; if (o_rdata !== exp_rdata) begin errors++; $display("FAIL rand%0d_rdata got %h want %h", i, o_rdata, exp_rdata); end
    end
  endtask

  task automatic test_back_to_back();
    xact(1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 0, 0, 32'h0);
    checks++; if (o_nstall != 2) begin errors++; $display("FAIL b2b_sw_stall got %0d want 2", o_nstall); end
    xact(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 0, 0, 32'hCAFEF00D);
    checks++; if (o_nstall != 3) begin errors++; $display("FAIL b2b_lhu_stall got %0d want 3", o_nstall); end
    checks++; if (o_rdata !== 32'h0000CAFE) begin errors++; $display("FAIL b2b_lhu_rdata got %h want 0000cafe", o_rdata); end
    xact(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 0, 0, 32'hCAFEF00D);
    checks++; if (o_rdata !== 32'hFFFFCAFE) begin errors++; $display("FAIL b2b_lh_rdata got %h want ffffcafe", o_rdata); end
    exp_rdata = 32'hFFFFCAFE;
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010; addr = 32'h40;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_read = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b want 1", bus_req); end
    @(posedge clk); #1;
    bus_gnt = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; bus_rvalid = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b want 0", stall); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got %h want 0", rdata); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h want 0", bus_addr); end
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata_after got %h want 0", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", err); end
    checks++; if (bus_be !== 4'b0000) begin errors++; $display("FAIL rmid_be got %b want 0000", bus_be); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall_after got %b want 0", stall); end
    exp_rdata = 32'h0;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    xact(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 1000, 0, 32'h0);
    checks++; if (o_hung) begin errors++; $display("FAIL to_hung got hung want done"); end
    checks++; if (o_nreq != 4) begin errors++; $display("FAIL to_req got %0d want 4", o_nreq); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", o_err); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h want 0", o_rdata); end
    checks++; if (o_nstall != 5) begin errors++; $display("FAIL to_stall got %0d want 5", o_nstall); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store unit directly downstream of the single-cycle datapath.
- Consumes the datapath's ALU result (as address), store data and func3.
- Drives a word-addressed data bus with a req/gnt/rvalid handshake, and returns sign/zero-extended load data to the datapath's memory-read-data input.
- Stalls the core (pc and register write held) while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ or WAIT_R before abort (only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-high (1 = reset).
- mem_read  in  1  load instruction in execute.
- mem_write  in  1  store instruction in execute.
- func3  in  3  access size/sign from the instruction.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load data to datapath writeback mux.
- stall  out  1  hold pc and suppress RegWrite.
- err  out  1  one-cycle pulse: misaligned/illegal access or timeout.
- bus_req  out  1  request, held until bus_gnt.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid; earliest one cycle after gnt.
- bus_rdata  in  32  read word.

Behaviour:
- Reset: state IDLE; rdata, bus_addr, bus_wdata = 0; bus_req, bus_we, err = 0; bus_be = 0000. Reset mid-transaction aborts it at the next edge; a later bus_rvalid in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, no op: stall = 0, no action.
- IDLE, legal op:
  - Register bus_addr/bus_we/bus_be/bus_wdata; bus_req = 1; go to REQ.
  - stall = 1 combinationally in this cycle.
- IDLE, illegal op: err = 1 next cycle, no bus activity, stay IDLE, stall = 0. Illegal means any of:
  - mem_read and mem_write both high;
  - func3 not in {000,001,010,100,101} for loads or {000,001,010} for stores;
  - LH/LHU/SH with addr[0] = 1;
  - LW/SW with addr[1:0] != 0.
- REQ: stall = 1; bus_req and all bus fields held stable.
  - On bus_gnt: bus_req = 0; a write goes to DONE, a read goes to WAIT_R.
- WAIT_R: stall = 1. On bus_rvalid: capture the extended data into rdata; go to DONE.
- DONE: stall = 0 for exactly one cycle; the core commits (rdata valid). Always go to IDLE. A new op presented in the following cycle starts normally.
- Load extraction uses lane = addr[1:0] captured at request time:
  - LB: byte at lane, sign-extended.
  - LBU: byte at lane, zero-extended.
  - LH: halfword at lane[1], sign-extended.
  - LHU: halfword at lane[1], zero-extended.
  - LW: full word.
- Store lanes:
  - SB: bus_be = 0001 << lane; bus_wdata = {4{wdata[7:0]}}.
  - SH: bus_be = 0011 << lane; bus_wdata = {2{wdata[15:0]}}.
  - SW: bus_be = 1111; bus_wdata = wdata.
- Reads drive bus_be = 1111.
- Latency with zero wait states:
  - Load: stall for 3 cycles (IDLE, REQ, WAIT_R); commits in the 4th.
  - Store: stall for 2 cycles; commits in the 3rd.
- rdata holds its last value except on a load capture; a store leaves it unchanged.
- err and a capture never coincide.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and counts every cycle in REQ/WAIT_R.
  - Reaching TIMEOUT_CYCLES: bus_req = 0, err pulses 1 cycle, rdata = 0, go to DONE (core commits).
- Undefined: no counter; the FSM waits indefinitely for gnt/rvalid.

Test Plan:
- LW addr 0x100, gnt same cycle as req, rvalid next cycle with bus_rdata 0xDEADBEEF -> stall high 3 cycles; rdata = 0xDEADBEEF in the DONE cycle; bus_be = 1111; bus_addr = 0x100.
- LB addr 0x203, bus_rdata 0x80FF_FF7F then LBU same -> rdata = 0xFFFFFF80, then 0x00000080.
- SH addr 0x302 wdata 0x1234ABCD, gnt delayed 3 cycles -> bus_req and all fields stable for 4 cycles; bus_be = 1100; bus_wdata = 0xABCDABCD; bus_addr = 0x300; stall low 1 cycle after gnt.
- LW addr 0x101 -> no bus_req; err = 1 one cycle; stall never high. Also mem_read = mem_write = 1 -> same response.
- Reset asserted in WAIT_R, then rvalid arrives -> outputs at reset values; rdata stays 0; no DONE.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES = 4, gnt never -> err at the 4th REQ cycle; rdata = 0; stall drops next cycle.
